// File: rtl/qdr2p_sram_controller.sv
// ---------------------------------------------------------------------------
// qdr2p_sram_controller
//
// Command/data core for a QDR-II+ burst-of-4 SRAM. It turns single-cycle
// 144-bit read/write requests into read-select/write-select, address and
// data slots for an external SDR 4:1 PHY. It also tracks reads in flight and
// hands captured read bursts back to the user in issue order.
//
// Ports
//   i_clk_ctl        controller clock (one cycle = one read + one write slot)
//   i_rst            synchronous reset, active high
//   i_phy_lock       PHY/RAM PLL locked
//   o_ready          controller initialised, requests accepted
//   i_rd_en/addr     read request strobe and burst address
//   o_rd_valid/data  read burst return (beat 0 in the MSBs)
//   i_wr_en/addr/data write request strobe, burst address and burst data
//   o_rd_overflow    sticky: read dropped because the tracker was full
//   o_rd_error       sticky: unexpected read return or read timeout
//   o_phy_rps_n      read select for this cycle's read slot (active low)
//   o_phy_wps_n      write select for this cycle's write slot (active low)
//   o_phy_rd_addr    address for the first K half
//   o_phy_wr_addr    address for the second K half
//   o_phy_bws_n      byte-write selects, 4 per beat (active low)
//   o_phy_wr_data    write burst for the PHY to serialise
//   i_phy_rd_valid   PHY captured a full read burst
//   i_phy_rd_data    captured read burst
// ---------------------------------------------------------------------------
module qdr2p_sram_controller #(
   parameter int RAM_WIDTH       = 36,
   parameter int ADDR_BITS       = 18,
   parameter int INIT_CYCLES     = 1024,
   parameter int MAX_OUTSTANDING = 8,
   parameter int RD_TIMEOUT      = 64
) (
   input  logic                   i_clk_ctl,
   input  logic                   i_rst,
   input  logic                   i_phy_lock,
   output logic                   o_ready,
   input  logic                   i_rd_en,
   input  logic [ADDR_BITS-1:0]   i_rd_addr,
   output logic                   o_rd_valid,
   output logic [4*RAM_WIDTH-1:0] o_rd_data,
   input  logic                   i_wr_en,
   input  logic [ADDR_BITS-1:0]   i_wr_addr,
   input  logic [4*RAM_WIDTH-1:0] i_wr_data,
   output logic                   o_rd_overflow,
   output logic                   o_rd_error,
   output logic                   o_phy_rps_n,
   output logic                   o_phy_wps_n,
   output logic [ADDR_BITS-1:0]   o_phy_rd_addr,
   output logic [ADDR_BITS-1:0]   o_phy_wr_addr,
   output logic [15:0]            o_phy_bws_n,
   output logic [4*RAM_WIDTH-1:0] o_phy_wr_data,
   input  logic                   i_phy_rd_valid,
   input  logic [4*RAM_WIDTH-1:0] i_phy_rd_data
);

   localparam int BURST_W = 4*RAM_WIDTH;
   localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
   localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int TO_W    = $clog2(RD_TIMEOUT + 1);

   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_SETTLE    = 2'd1,
      S_RUN       = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [INIT_W-1:0]   r_init_cnt;
   logic [INIT_W-1:0]   w_init_cnt_nxt;

   logic                w_ready;
   logic                w_full;
   logic                w_empty;
   logic                w_rd_issue;
   logic                w_rd_drop;
   logic                w_wr_issue;
   logic                w_ret_ok;
   logic                w_ret_stray;
   logic                w_to_hit;

   logic [CNT_W-1:0]    r_out_cnt;
   logic [TO_W-1:0]     r_to_cnt;

   logic                r_rd_vld_p1;
   logic                r_wr_vld_p1;
   logic [ADDR_BITS-1:0] r_rd_addr_p1;
   logic [ADDR_BITS-1:0] r_wr_addr_p1;
   logic [BURST_W-1:0]  r_wr_data_p1;
   logic [BURST_W-1:0]  r_wr_data_p2;
   logic [15:0]         r_bws_n_p2;

   logic                r_rd_vld_ret;
   logic [BURST_W-1:0]  r_rd_data_ret;
   logic                r_overflow;
   logic                r_error;

   // ------------------------------------------------------------------
   // Init sequencer: wait for lock, let the RAM DLL settle, then run.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk_ctl) begin
      if (i_rst) begin
         r_state    <= S_WAIT_LOCK;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      case (r_state)
         S_WAIT_LOCK: begin
            w_init_cnt_nxt = '0;
            if (i_phy_lock) w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (!i_phy_lock) begin
               w_state_nxt    = S_WAIT_LOCK;
               w_init_cnt_nxt = '0;
            end else if (r_init_cnt == INIT_LAST) begin
               w_state_nxt    = S_RUN;
               w_init_cnt_nxt = '0;
            end else begin
               w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
            end
         end
         S_RUN: begin
            if (!i_phy_lock) w_state_nxt = S_WAIT_LOCK;
         end
         default: begin
            w_state_nxt    = S_WAIT_LOCK;
            w_init_cnt_nxt = '0;
         end
      endcase
   end

   assign w_ready = (r_state == S_RUN);

   // Requests and returns outside RUN are ignored, which also covers the
   // window after reset while stale PHY returns drain.
   assign w_full      = (r_out_cnt == CNT_FULL);
   assign w_empty     = (r_out_cnt == '0);
   assign w_rd_issue  = i_rd_en & w_ready & ~w_full;
   assign w_rd_drop   = i_rd_en & w_ready &  w_full;
   assign w_wr_issue  = i_wr_en & w_ready;
   assign w_ret_ok    = i_phy_rd_valid & w_ready & ~w_empty;
   assign w_ret_stray = i_phy_rd_valid & w_ready &  w_empty;
   assign w_to_hit    = w_ready & ~w_empty & ~i_phy_rd_valid & (r_to_cnt == TO_LAST);

   // ------------------------------------------------------------------
   // Read tracker: outstanding count and return timeout.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk_ctl) begin
      if (i_rst || !w_ready || w_to_hit) begin
         r_out_cnt <= '0;
      end else if (w_rd_issue && !w_ret_ok) begin
         r_out_cnt <= r_out_cnt + CNT_W'(1);
      end else if (!w_rd_issue && w_ret_ok) begin
         r_out_cnt <= r_out_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk_ctl) begin
      if (i_rst || !w_ready || w_empty || w_ret_ok || w_to_hit) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Stage p1: command slot (RPS#/WPS# and addresses).
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk_ctl) begin
      if (i_rst) begin
         r_rd_vld_p1  <= 1'b0;
         r_wr_vld_p1  <= 1'b0;
         r_rd_addr_p1 <= '0;
         r_wr_addr_p1 <= '0;
      end else begin
         r_rd_vld_p1 <= w_rd_issue;
         r_wr_vld_p1 <= w_wr_issue;
         if (w_rd_issue) r_rd_addr_p1 <= i_rd_addr;
         if (w_wr_issue) r_wr_addr_p1 <= i_wr_addr;
      end
   end

   always_ff @(posedge i_clk_ctl) begin
      if (w_wr_issue) r_wr_data_p1 <= i_wr_data;
   end

   // ------------------------------------------------------------------
   // Stage p2: write data and byte selects, one cycle behind WPS#.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk_ctl) begin
      if (i_rst) begin
         r_wr_data_p2 <= '0;
         r_bws_n_p2   <= 16'hFFFF;
      end else if (r_wr_vld_p1) begin
         r_wr_data_p2 <= r_wr_data_p1;
         r_bws_n_p2   <= 16'h0000;
      end else begin
         r_wr_data_p2 <= '0;
         r_bws_n_p2   <= 16'hFFFF;
      end
   end

   // ------------------------------------------------------------------
   // Return stage: register captured bursts and sticky status.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk_ctl) begin
      if (i_rst) begin
         r_rd_vld_ret  <= 1'b0;
         r_rd_data_ret <= '0;
         r_overflow    <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_rd_vld_ret  <= w_ret_ok;
         r_rd_data_ret <= w_ret_ok ? i_phy_rd_data : '0;
         if (w_rd_drop)              r_overflow <= 1'b1;
         if (w_ret_stray || w_to_hit) r_error   <= 1'b1;
      end
   end

   assign o_ready       = w_ready;
   assign o_rd_valid    = r_rd_vld_ret;
   assign o_rd_data     = r_rd_data_ret;
   assign o_rd_overflow = r_overflow;
   assign o_rd_error    = r_error;
   assign o_phy_rps_n   = ~r_rd_vld_p1;
   assign o_phy_wps_n   = ~r_wr_vld_p1;
   assign o_phy_rd_addr = r_rd_addr_p1;
   assign o_phy_wr_addr = r_wr_addr_p1;
   assign o_phy_bws_n   = r_bws_n_p2;
   assign o_phy_wr_data = r_wr_data_p2;

endmodule

// File: tb/tb_qdr2p_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_qdr2p_sram_controller
//
// Scoreboard bench. A reference memory predicts each read at request time
// and pushes the expectation into a queue; a monitor pops on rd_valid. A
// behavioural QDR RAM + PHY model answers the controller's command slots.
// ---------------------------------------------------------------------------
module tb_qdr2p_sram_controller;

   localparam int RW   = 36;
   localparam int AB   = 18;
   localparam int INIT = 32;
   localparam int MAXO = 8;
   localparam int RTO  = 64;
   localparam int BW   = 4*RW;

   logic          clk = 1'b0;
   logic          rst, phy_lock;
   logic          rd_en, wr_en;
   logic [AB-1:0] rd_addr, wr_addr;
   logic [BW-1:0] wr_data;
   logic          phy_rd_valid;
   logic [BW-1:0] phy_rd_data;

   logic          o_ready, o_rd_valid, o_rd_overflow, o_rd_error;
   logic [BW-1:0] o_rd_data, o_phy_wr_data;
   logic          o_phy_rps_n, o_phy_wps_n;
   logic [AB-1:0] o_phy_rd_addr, o_phy_wr_addr;
   logic [15:0]   o_phy_bws_n;

   always #5 clk = ~clk;

   qdr2p_sram_controller #(
      .RAM_WIDTH(RW), .ADDR_BITS(AB), .INIT_CYCLES(INIT),
      .MAX_OUTSTANDING(MAXO), .RD_TIMEOUT(RTO)
   ) dut (
      .i_clk_ctl(clk), .i_rst(rst), .i_phy_lock(phy_lock), .o_ready(o_ready),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_rd_overflow(o_rd_overflow), .o_rd_error(o_rd_error),
      .o_phy_rps_n(o_phy_rps_n), .o_phy_wps_n(o_phy_wps_n),
      .o_phy_rd_addr(o_phy_rd_addr), .o_phy_wr_addr(o_phy_wr_addr),
      .o_phy_bws_n(o_phy_bws_n), .o_phy_wr_data(o_phy_wr_data),
      .i_phy_rd_valid(phy_rd_valid), .i_phy_rd_data(phy_rd_data)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] rnd144();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[BW-1:0];
   endfunction

   // Reference model: memory contents as seen by the user, plus pending
   // read expectations in issue order.
   logic [BW-1:0] ref_mem [int];
   logic [BW-1:0] exp_q [$];
   int            mdl_cnt = 0;

   function automatic logic [BW-1:0] ref_rd(input logic [AB-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return '0;
   endfunction

   // QDR RAM + PHY model.
   typedef struct {
      logic [BW-1:0] d;
      int            due;
   } ret_t;

   logic [BW-1:0] ram [int];
   ret_t          rq [$];
   int            wq [$];
   ret_t          tmp_r;
   int            cyc = 0;
   bit            stall = 0;
   bit            stray_req = 0;

   function automatic logic [BW-1:0] ram_rd(input logic [AB-1:0] a);
      if (ram.exists(int'(a))) return ram[int'(a)];
      return '0;
   endfunction

   initial begin
      phy_rd_valid = 1'b0;
      phy_rd_data  = '0;
   end

   always @(posedge clk) begin
      #2;
      cyc++;
      // Data for a write selected last cycle lands before this cycle's read.
      if (o_phy_bws_n == 16'h0000 && wq.size() > 0) ram[wq.pop_front()] = o_phy_wr_data;
      if (!o_phy_wps_n) wq.push_back(int'(o_phy_wr_addr));
      if (!o_phy_rps_n) begin
         tmp_r.d   = ram_rd(o_phy_rd_addr);
         tmp_r.due = cyc + 2;
         rq.push_back(tmp_r);
      end
      phy_rd_valid = 1'b0;
      phy_rd_data  = '0;
      if (stray_req) begin
         phy_rd_valid = 1'b1;
         phy_rd_data  = rnd144();
         stray_req    = 0;
      end else if (!stall && rq.size() > 0 && rq[0].due <= cyc) begin
         tmp_r        = rq.pop_front();
         phy_rd_valid = 1'b1;
         phy_rd_data  = tmp_r.d;
         if (mdl_cnt > 0) mdl_cnt--;
      end
   end

   // Monitor.
   bit mon_en = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_rd_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_unexpected: got rd_valid data %0h expected no return", o_rd_data);
            end else begin
               chk("rd_data", o_rd_data, exp_q.pop_front());
            end
         end else begin
            chk("rd_data_idle", o_rd_data, '0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit rd, input logic [AB-1:0] ra,
                        input bit wr, input logic [AB-1:0] wa, input logic [BW-1:0] wd);
      if (rd && o_ready && mdl_cnt < MAXO) begin
         exp_q.push_back(ref_rd(ra));
         mdl_cnt++;
      end
      if (wr && o_ready) ref_mem[int'(wa)] = wd;
      rd_en = rd; rd_addr = ra; wr_en = wr; wr_addr = wa; wr_data = wd;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain", BW'(exp_q.size()), '0);
      tick();
      tick();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!o_ready && n < INIT + 20) begin
         tick();
         n++;
      end
      chk("ready_up", BW'(o_ready), BW'(1));
   endtask

   localparam logic [BW-1:0] D1  = 144'h0_deadbeef_1_baadc0de_2_feedface_3_c0def00d;
   localparam logic [BW-1:0] DF1 = 144'ha_41414141_b_69696969_c_cccccccc_d_cd80cd80;
   localparam logic [BW-1:0] DF2 = 144'he_eeeeeeee_f_ffffffff_0_00000000_1_11111111;

   initial begin
      int n;
      logic [BW-1:0] dnew;
      rst = 1'b1; phy_lock = 1'b0;
      rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) tick();

      // Reset values.
      chk("rst_ready",    BW'(o_ready),       '0);
      chk("rst_rd_valid", BW'(o_rd_valid),    '0);
      chk("rst_rd_data",  o_rd_data,          '0);
      chk("rst_ovf",      BW'(o_rd_overflow), '0);
      chk("rst_err",      BW'(o_rd_error),    '0);
      chk("rst_rps_n",    BW'(o_phy_rps_n),   BW'(1));
      chk("rst_wps_n",    BW'(o_phy_wps_n),   BW'(1));
      chk("rst_bws_n",    BW'(o_phy_bws_n),   BW'(16'hFFFF));
      chk("rst_rd_addr",  BW'(o_phy_rd_addr), '0);
      chk("rst_wr_addr",  BW'(o_phy_wr_addr), '0);
      chk("rst_wr_data",  o_phy_wr_data,      '0);
      mon_en = 1;
      rst = 1'b0;
      tick();

      // Requests before ready are dropped.
      issue(1, 18'h00005, 1, 18'h00006, D1);
      chk("pre_ready_rps_n", BW'(o_phy_rps_n), BW'(1));
      chk("pre_ready_wps_n", BW'(o_phy_wps_n), BW'(1));

      // Init latency from phy_lock to ready.
      phy_lock = 1'b1;
      n = 0;
      while (!o_ready && n < INIT + 20) begin
         tick();
         n++;
      end
      chk("init_latency", BW'(n), BW'(INIT + 1));

      // Single write: WPS# at N+1, data/BWS# at N+2.
      issue(0, '0, 1, 18'h0BEEF, D1);
      chk("wr_wps_n",     BW'(o_phy_wps_n),   '0);
      chk("wr_addr",      BW'(o_phy_wr_addr), BW'(18'h0BEEF));
      chk("wr_bws_early", BW'(o_phy_bws_n),   BW'(16'hFFFF));
      tick();
      chk("wr_data",      o_phy_wr_data,      D1);
      chk("wr_bws",       BW'(o_phy_bws_n),   '0);
      chk("wr_wps_n_off", BW'(o_phy_wps_n),   BW'(1));
      tick();
      chk("wr_data_idle", o_phy_wr_data,      '0);
      chk("wr_bws_idle",  BW'(o_phy_bws_n),   BW'(16'hFFFF));

      // Single read back.
      issue(1, 18'h0BEEF, 0, '0, '0);
      chk("rd_rps_n", BW'(o_phy_rps_n),   '0);
      chk("rd_addr",  BW'(o_phy_rd_addr), BW'(18'h0BEEF));
      tick();
      chk("rd_rps_n_off", BW'(o_phy_rps_n), BW'(1));
      drain();

      // Back-to-back writes then reads.
      issue(0, '0, 1, 18'h0FEED, DF1);
      issue(0, '0, 1, 18'h0FACE, DF2);
      issue(1, 18'h0FEED, 0, '0, '0);
      issue(1, 18'h0FACE, 0, '0, '0);
      drain();

      // Same-cycle read and write to one address: read sees old contents.
      dnew = rnd144();
      issue(1, 18'h0BEEF, 1, 18'h0BEEF, dnew);
      issue(1, 18'h0BEEF, 0, '0, '0);
      drain();

      // Randomized mixed traffic over a small address window.
      for (int i = 0; i < 300; i++) begin
         issue(bit'($urandom_range(0, 1)), AB'(18'h00100 + $urandom_range(0, 15)),
               bit'($urandom_range(0, 1)), AB'(18'h00100 + $urandom_range(0, 15)), rnd144());
      end
      drain();

      // Tracker full: ninth read is dropped.
      stall = 1;
      for (int i = 0; i < 9; i++) issue(1, AB'(18'h00100 + i), 0, '0, '0);
      tick();
      chk("ovf_flag",   BW'(o_rd_overflow), BW'(1));
      chk("ovf_issued", BW'(rq.size()),     BW'(MAXO));
      chk("ovf_no_err", BW'(o_rd_error),    '0);
      stall = 0;
      drain();

      // Stray return with nothing pending.
      stray_req = 1;
      repeat (3) tick();
      chk("stray_err", BW'(o_rd_error), BW'(1));

      // Reset with three reads pending and a write in its command slot.
      stall = 1;
      issue(1, 18'h00101, 0, '0, '0);
      issue(1, 18'h00102, 0, '0, '0);
      issue(1, 18'h00103, 1, 18'h3FFFF, rnd144());
      chk("mid_rps_pre", BW'(o_phy_rps_n), '0);
      rst = 1'b1;
      tick();
      chk("mid_rps_n",  BW'(o_phy_rps_n),   BW'(1));
      chk("mid_wps_n",  BW'(o_phy_wps_n),   BW'(1));
      chk("mid_bws_n",  BW'(o_phy_bws_n),   BW'(16'hFFFF));
      chk("mid_ready",  BW'(o_ready),       '0);
      chk("mid_ovf",    BW'(o_rd_overflow), '0);
      chk("mid_err",    BW'(o_rd_error),    '0);
      exp_q.delete();
      mdl_cnt = 0;
      stall = 0;
      tick();
      rst = 1'b0;
      wq.delete();
      repeat (10) tick();
      chk("mid_err_after", BW'(o_rd_error), '0);
      wait_ready();

      // Read timeout with a return held back.
      stall = 1;
      issue(1, 18'h0FEED, 0, '0, '0);
      repeat (RTO - 2) tick();
      chk("to_not_yet", BW'(o_rd_error), '0);
      repeat (3) tick();
      chk("to_err", BW'(o_rd_error), BW'(1));
      exp_q.delete();
      mdl_cnt = 0;
      rq.delete();
      stall = 0;
      tick();

      // Traffic still flows after a timeout.
      issue(1, 18'h0FACE, 0, '0, '0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

endmodule
